// File: rtl/adjust_key_ctrl_if.sv
// Key/strobe inputs and pulse outputs between the key conditioner and its environment.
// master drives the keys, enable and frame strobe; slave is the conditioner itself.
interface adjust_key_ctrl_if;
  logic enable;
  logic frame_en;
  logic key_inc_n;
  logic key_dec_n;
  logic inc;
  logic dec;
  logic key_busy;

  modport master (
    output enable,
    output frame_en,
    output key_inc_n,
    output key_dec_n,
    input  inc,
    input  dec,
    input  key_busy
  );

  modport slave (
    input  enable,
    input  frame_en,
    input  key_inc_n,
    input  key_dec_n,
    output inc,
    output dec,
    output key_busy
  );
endinterface

// File: rtl/adjust_key_ctrl.sv
// Key conditioner for the contrast stage: sync + debounce two keys, emit frame-aligned inc/dec pulses.
// Define AUTO_REPEAT_EN to build hold-to-repeat (DELAY/RPT); otherwise one pulse per press (HOLD).
module adjust_key_ctrl #(
  parameter int DB_CNT       = 1000000,
  parameter int DB_W         = 20,
  parameter int RPT_DELAY_FR = 30,
  parameter int RPT_RATE_FR  = 6
) (
  input logic              clk,
  input logic              rst_n,
  adjust_key_ctrl_if.slave bus
);
  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

`ifdef AUTO_REPEAT_EN
  localparam int FR_MAX = (RPT_DELAY_FR > RPT_RATE_FR) ? RPT_DELAY_FR : RPT_RATE_FR;
  localparam int FR_W   = $clog2(FR_MAX + 1);
  localparam logic [FR_W-1:0] FR_SAT   = FR_W'(FR_MAX);
  localparam logic [FR_W-1:0] FR_DELAY = FR_W'(RPT_DELAY_FR);
  localparam logic [FR_W-1:0] FR_RATE  = FR_W'(RPT_RATE_FR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_DELAY = 3'd2,
    S_RPT   = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d, frame_nxt_s;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2,
    S_LOCK = 2'd3
  } state_e;
`endif

  // Synchronisers hold the raw active-low level; debounced state is active-high "pressed".
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      db_q, db_d;
  logic [1:0]      db_prev_q, db_prev_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   busy_q, busy_d;

  logic [1:0] press_s;
  logic       both_s;
  logic       any_s;
  logic       held_s;
  logic       pulse_s;

  assign press_s = db_q & ~db_prev_q;
  assign both_s  = db_q[KEY_INC] & db_q[KEY_DEC];
  assign any_s   = db_q[KEY_INC] | db_q[KEY_DEC];
  assign held_s  = db_q[dir_q];
`ifdef AUTO_REPEAT_EN
  assign frame_nxt_s = (frame_cnt_q == FR_SAT) ? frame_cnt_q : frame_cnt_q + FR_W'(1);
`endif

  // Debounce: count only while the synchronised level disagrees with the debounced state.
  always_comb begin
    sync1_d   = {bus.key_dec_n, bus.key_inc_n};
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = {DB_W{1'b0}};
      if (~sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          db_d[k]  = ~db_q[k];
          cnt_d[k] = {DB_W{1'b0}};
        end else begin
          cnt_d[k] = cnt_q[k] + DB_W'(1);
        end
      end else begin
        cnt_d[k] = {DB_W{1'b0}};
      end
    end
  end

  // Control FSM: disable and dual-press override every state; pulses only on frame_en.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pulse_s = 1'b0;
`ifdef AUTO_REPEAT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    if (!bus.enable) begin
      state_d = any_s ? S_LOCK : S_IDLE;
    end else if (both_s) begin
      state_d = S_LOCK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_s[KEY_INC]) begin
            state_d = S_PEND;
            dir_d   = 1'b0;
          end else if (press_s[KEY_DEC]) begin
            state_d = S_PEND;
            dir_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PEND: begin
          if (!held_s) begin
            state_d = S_IDLE;
          end else if (bus.frame_en) begin
            pulse_s = 1'b1;
`ifdef AUTO_REPEAT_EN
            state_d     = S_DELAY;
            frame_cnt_d = {FR_W{1'b0}};
`else
            state_d = S_HOLD;
`endif
          end else begin
            state_d = S_PEND;
          end
        end
`ifdef AUTO_REPEAT_EN
        S_DELAY, S_RPT: begin
          if (!held_s) begin
            state_d = S_IDLE;
          end else if (bus.frame_en) begin
            if (frame_nxt_s == ((state_q == S_DELAY) ? FR_DELAY : FR_RATE)) begin
              pulse_s     = 1'b1;
              state_d     = S_RPT;
              frame_cnt_d = {FR_W{1'b0}};
            end else begin
              frame_cnt_d = frame_nxt_s;
            end
          end else begin
            state_d = state_q;
          end
        end
`else
        S_HOLD: begin
          if (!held_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
`endif
        S_LOCK: begin
          if (!any_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LOCK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    inc_d  = pulse_s & ~dir_q;
    dec_d  = pulse_s & dir_q;
    busy_d = any_s;
  end

  // All state, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_q      <= 2'b00;
      db_prev_q <= 2'b00;
      cnt_q[0]  <= {DB_W{1'b0}};
      cnt_q[1]  <= {DB_W{1'b0}};
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      frame_cnt_q <= {FR_W{1'b0}};
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      state_q   <= state_d;
      dir_q     <= dir_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      busy_q    <= busy_d;
`ifdef AUTO_REPEAT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign bus.inc      = inc_q;
  assign bus.dec      = dec_q;
  assign bus.key_busy = busy_q;
endmodule

// File: tb/tb_adjust_key_ctrl.sv
// Self-checking bench for adjust_key_ctrl: scenario table, hand-written corner sequences and
// randomized key activity compared every cycle against a behavioural model.
module tb_adjust_key_ctrl;
  localparam int DB_CNT    = 4;
  localparam int RPT_DELAY = 3;
  localparam int RPT_RATE  = 2;
  localparam int FRAME     = 20;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_HELD = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  adjust_key_ctrl_if bus_if ();

  adjust_key_ctrl #(
    .DB_CNT(DB_CNT), .DB_W(3), .RPT_DELAY_FR(RPT_DELAY), .RPT_RATE_FR(RPT_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_inc = 0;
  int cnt_dec = 0;
  logic k_inc_n = 1'b1;
  logic k_dec_n = 1'b1;
  logic en_v = 1'b1;
  logic rst_v = 1'b0;

  // Behavioural model: raw history per edge, debounce as "DB_CNT consecutive disagreeing samples".
  bit [1:0] m_hist[$];
  int       m_e;
  bit [1:0] m_db, m_db_prev;
  int       m_last[2];
  int       m_mode, m_n;
  bit       m_dir;
  bit       exp_inc, exp_dec, exp_busy;

  typedef struct packed {
    logic        sel;       // 0 = inc key, 1 = dec key
    logic [15:0] len;       // cycles held low, starting at a frame-aligned cycle
    logic [7:0]  exp_inc;
    logic [7:0]  exp_dec;
  } vec_t;
  vec_t tab[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_e = 0;
    m_db = 2'b00;
    m_db_prev = 2'b00;
    m_last[0] = -1000;
    m_last[1] = -1000;
    m_mode = M_IDLE;
    m_n = 0;
    m_dir = 1'b0;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    exp_busy = 1'b0;
  endtask

  // Synchronised pressed level seen at edge x is the raw level sampled two edges earlier.
  function automatic bit m_sync(input int x, input int k);
    bit [1:0] v;
    if (x < 2) return 1'b0;
    v = m_hist[x-2];
    return v[k];
  endfunction

  task automatic model_step();
    bit [1:0] rise, nd;
    bit pulse, held, ok;
    m_hist.push_back(~{bus_if.key_dec_n, bus_if.key_inc_n});
    rise  = m_db & ~m_db_prev;
    held  = m_db[m_dir];
    pulse = 1'b0;
    if (!bus_if.enable) m_mode = (m_db != 2'b00) ? M_LOCK : M_IDLE;
    else if (m_db == 2'b11) m_mode = M_LOCK;
    else begin
      case (m_mode)
        M_IDLE: begin
          if (rise[0]) begin m_mode = M_WAIT; m_dir = 1'b0; end
          else if (rise[1]) begin m_mode = M_WAIT; m_dir = 1'b1; end
        end
        M_WAIT: begin
          if (!held) m_mode = M_IDLE;
          else if (bus_if.frame_en) begin pulse = 1'b1; m_mode = M_HELD; m_n = 0; end
        end
        M_HELD: begin
          if (!held) m_mode = M_IDLE;
          else if (bus_if.frame_en) begin
            m_n++;
            if (AUTO && m_n >= RPT_DELAY && ((m_n - RPT_DELAY) % RPT_RATE) == 0) pulse = 1'b1;
          end
        end
        M_LOCK: if (m_db == 2'b00) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    exp_inc  = pulse & ~m_dir;
    exp_dec  = pulse & m_dir;
    exp_busy = |m_db;
    nd = m_db;
    for (int k = 0; k < 2; k++) begin
      ok = (m_e - m_last[k] >= DB_CNT);
      for (int j = 0; j < DB_CNT; j++) if (m_sync(m_e - j, k) == m_db[k]) ok = 1'b0;
      if (ok) begin nd[k] = ~m_db[k]; m_last[k] = m_e; end
    end
    m_db_prev = m_db;
    m_db = nd;
    m_e++;
  endtask

  // One clock: compare last edge's outputs, then drive inputs for the next edge.
  task automatic tick();
    @(negedge clk);
    check("inc", int'(bus_if.inc), int'(exp_inc));
    check("dec", int'(bus_if.dec), int'(exp_dec));
    check("key_busy", int'(bus_if.key_busy), int'(exp_busy));
    if (bus_if.inc) cnt_inc++;
    if (bus_if.dec) cnt_dec++;
    bus_if.key_inc_n = k_inc_n;
    bus_if.key_dec_n = k_dec_n;
    bus_if.enable    = en_v;
    bus_if.frame_en  = (cyc % FRAME == FRAME - 1);
    rst_n = rst_v;
    cyc++;
    if (rst_v) model_step();
    else model_reset();
  endtask

  task automatic align();
    while (cyc % FRAME != 0) tick();
    cnt_inc = 0;
    cnt_dec = 0;
  endtask

  initial begin
    int rem_i, rem_d, rem_e;
    bus_if.enable = 1'b1;
    bus_if.frame_en = 1'b0;
    bus_if.key_inc_n = 1'b1;
    bus_if.key_dec_n = 1'b1;
    model_reset();

    tab[0] = '{sel: 1'b0, len: 16'd3,   exp_inc: 8'd0, exp_dec: 8'd0};
    tab[1] = '{sel: 1'b0, len: 16'd4,   exp_inc: 8'd0, exp_dec: 8'd0};
    tab[2] = '{sel: 1'b0, len: 16'd13,  exp_inc: 8'd0, exp_dec: 8'd0};
    tab[3] = '{sel: 1'b0, len: 16'd14,  exp_inc: 8'd1, exp_dec: 8'd0};
    tab[4] = '{sel: 1'b0, len: 16'd30,  exp_inc: 8'd1, exp_dec: 8'd0};
    tab[5] = '{sel: 1'b1, len: 16'd30,  exp_inc: 8'd0, exp_dec: 8'd1};
    tab[6] = '{sel: 1'b1, len: 16'd200, exp_inc: 8'd0, exp_dec: AUTO ? 8'd5 : 8'd1};
    tab[7] = '{sel: 1'b0, len: 16'd60,  exp_inc: 8'd1, exp_dec: 8'd0};

    repeat (3) tick();
    rst_v = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 8; i++) begin
      align();
      if (tab[i].sel) k_dec_n = 1'b0;
      else k_inc_n = 1'b0;
      for (int c = 0; c < int'(tab[i].len); c++) tick();
      k_inc_n = 1'b1;
      k_dec_n = 1'b1;
      repeat (40) tick();
      check($sformatf("vec%0d_inc_count", i), cnt_inc, int'(tab[i].exp_inc));
      check($sformatf("vec%0d_dec_count", i), cnt_dec, int'(tab[i].exp_dec));
    end

    // Both keys: dec first, inc two frames later -> lock; partial release stays locked.
    align();
    k_dec_n = 1'b0;
    repeat (40) tick();
    k_inc_n = 1'b0;
    repeat (80) tick();
    check("both_dec_count", cnt_dec, 1);
    check("both_inc_count", cnt_inc, 0);
    cnt_inc = 0; cnt_dec = 0;
    k_inc_n = 1'b1;
    repeat (40) tick();
    k_dec_n = 1'b1;
    repeat (40) tick();
    check("lock_release_pulses", cnt_inc + cnt_dec, 0);
    align();
    k_inc_n = 1'b0;
    repeat (30) tick();
    k_inc_n = 1'b1;
    repeat (40) tick();
    check("after_lock_inc_count", cnt_inc, 1);

    // Enable low while inc is pressed, raised with the key still held.
    align();
    en_v = 1'b0;
    k_inc_n = 1'b0;
    repeat (30) tick();
    en_v = 1'b1;
    repeat (30) tick();
    k_inc_n = 1'b1;
    repeat (40) tick();
    check("enable_held_pulses", cnt_inc + cnt_dec, 0);
    align();
    k_inc_n = 1'b0;
    repeat (30) tick();
    k_inc_n = 1'b1;
    repeat (40) tick();
    check("after_enable_inc_count", cnt_inc, 1);

    // Asynchronous reset in the middle of auto-repeat.
    align();
    k_inc_n = 1'b0;
    repeat (100) tick();
    check("rpt_before_reset", cnt_inc, AUTO ? 2 : 1);
    #2 rst_n = 1'b0;
    rst_v = 1'b0;
    model_reset();
    #1;
    check("rst_async_inc", int'(bus_if.inc), 0);
    check("rst_async_dec", int'(bus_if.dec), 0);
    check("rst_async_busy", int'(bus_if.key_busy), 0);
    repeat (3) tick();
    rst_v = 1'b1;
    repeat (60) tick();
    k_inc_n = 1'b1;
    repeat (40) tick();

    // Randomized key activity, enable toggling and rare resets.
    rem_i = 0; rem_d = 0; rem_e = 0;
    for (int c = 0; c < 5000; c++) begin
      if (rem_i == 0) begin
        k_inc_n = ($urandom_range(0, 99) < 55);
        rem_i = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 90);
      end
      rem_i--;
      if (rem_d == 0) begin
        k_dec_n = ($urandom_range(0, 99) < 60);
        rem_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 90);
      end
      rem_d--;
      if (rem_e == 0) begin
        en_v = ($urandom_range(0, 7) != 0);
        rem_e = $urandom_range(5, 80);
      end
      rem_e--;
      rst_v = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_v = 1'b1;
    k_inc_n = 1'b1;
    k_dec_n = 1'b1;
    en_v = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
